branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- ID-stage branch resolution for the 5-stage MIPS pipeline.
- Forwards branch operands from MEM, compares them for beq/bne, and computes the branch target.
- Stalls IF/ID and bubbles EX while an operand is still in flight.
- Drives PC source and IF/ID flush, and keeps saturating branch and taken counters.
- Sits between the register file/IF-ID register and the PC mux. It replaces the bare equality comparator in ID.

Parameters:
- WIDTH, 32, datapath and PC width.
- RADDR, 5, register-specifier width.
- CNTW, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- branch_d  in  1  instruction in ID is a conditional branch.
- bne_d  in  1  1 = bne, 0 = beq (valid with branch_d).
- rs_d, rt_d  in  RADDR  source specifiers in ID.
- rd1_d, rd2_d  in  WIDTH  register-file read data. The register file is write-first, so WB forwarding is implicit.
- imm_d  in  WIDTH  sign-extended immediate.
- pc_plus4_d  in  WIDTH  PC+4 of the branch.
- regwrite_e, memtoreg_e  in  1  EX-stage control.
- writereg_e  in  RADDR  EX destination.
- regwrite_m, memtoreg_m  in  1  MEM-stage control.
- writereg_m  in  RADDR  MEM destination.
- aluout_m  in  WIDTH  MEM-stage ALU result.
- stall_f, stall_d  out  1  hold PC and IF/ID.
- flush_e  out  1  insert bubble into ID/EX.
- pcsrc_d  out  1  take branch target this cycle.
- flush_d  out  1  squash IF/ID (no delay slot).
- pc_branch_d  out  WIDTH  branch target.
- branch_cnt, taken_cnt  out  CNTW  resolved / taken branch counts.

Behaviour:
- Single clock, clk. Reset rst is synchronous, active-high. All state updates on the rising edge.
- Reset: state=IDLE, cnt=0, branch_cnt=0, taken_cnt=0.
- Reset is honoured mid-stall: the next cycle is IDLE with all stall/flush outputs 0 unless a new hazard is detected combinationally.

Operand forwarding (combinational):
- a = aluout_m if regwrite_m & !memtoreg_m & writereg_m!=0 & writereg_m==rs_d; otherwise a = rd1_d.
- b is formed the same way with rt_d and rd2_d.
- Register 0 is never forwarded or hazard-checked.

Hazards (combinational, evaluated only in IDLE):
- hz_e = branch_d & regwrite_e & writereg_e!=0 & (writereg_e==rs_d | writereg_e==rt_d).
- hz_m = branch_d & regwrite_m & memtoreg_m & writereg_m!=0 & (writereg_m==rs_d | writereg_m==rt_d).
- Stall need: 2 cycles if hz_e & memtoreg_e; 1 cycle if hz_e (ALU producer) or hz_m; otherwise 0.

FSM:
- IDLE, need=0: no stall.
  - pcsrc_d = flush_d = branch_d & ((a==b) ^ bne_d).
  - If branch_d, branch_cnt increments; if also taken, taken_cnt increments.
- IDLE, need>=1:
  - stall_f = stall_d = flush_e = 1; pcsrc_d = flush_d = 0; no counter update.
  - need=2: next state HOLD with cnt=1.
  - need=1: remain IDLE and re-evaluate next cycle.
- HOLD:
  - stall_f = stall_d = flush_e = 1; pcsrc_d = 0; hazard inputs ignored.
  - cnt decrements; return to IDLE when cnt reaches 0. HOLD lasts exactly cnt cycles.
- Stall and taken are never asserted in the same cycle. A stalled branch resolves exactly once, in its first hazard-free IDLE cycle.

Arithmetic and counters:
- pc_branch_d = pc_plus4_d + (imm_d << 2), mod 2^WIDTH. Wrap-around is permitted; no overflow flag.
- pc_branch_d is valid every cycle regardless of branch_d.
- Counters saturate at 2^CNTW-1 and do not wrap.
- Resolution outputs are combinational, so branch resolution latency is 0 cycles after the operands are clean.
- Counters update on the edge ending the resolution cycle.

Test Plan:
- beq $1,$2 with rd1_d=rd2_d=0x0000_0005, no hazards, pc_plus4_d=0x0040_0010, imm_d=0x0000_0004 -> same cycle pcsrc_d=1, flush_d=1, pc_branch_d=0x0040_0020; next cycle branch_cnt=1, taken_cnt=1.
- bne with a=b=0x1234 -> pcsrc_d=0; branch_cnt increments, taken_cnt unchanged. Then pc_plus4_d=0x0000_0004 with imm_d=0xFFFF_FFFE -> pc_branch_d=0xFFFF_FFFC (wrap).
- add $3 in EX (regwrite_e=1, memtoreg_e=0), beq $3,$0 in ID -> 1 stall cycle (stall_f=stall_d=flush_e=1). Next cycle the producer is in MEM, a=aluout_m=0 forwarded, branch taken.
- lw $4 in EX, bne $4,$5 in ID -> stall 2 cycles (IDLE then HOLD), then resolves using rd1_d; branch_cnt increments exactly once.
- Assert rst during the HOLD cycle of the lw case -> next cycle state IDLE, outputs 0, counters 0. Also verify writereg_e=0 with regwrite_e=1 never stalls.
- Force branch_cnt to 0xFFFF via 65535 non-taken branches, then one more branch -> branch_cnt stays 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage beq/bne resolution with MEM forwarding, load/ALU hazard stalls and branch counters
module branch_resolve_unit #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_branch_d,
    input  logic             i_bne_d,
    input  logic [RADDR-1:0] i_rs_d,
    input  logic [RADDR-1:0] i_rt_d,
    input  logic [WIDTH-1:0] i_rd1_d,
    input  logic [WIDTH-1:0] i_rd2_d,
    input  logic [WIDTH-1:0] i_imm_d,
    input  logic [WIDTH-1:0] i_pc_plus4_d,
    input  logic             i_regwrite_e,
    input  logic             i_memtoreg_e,
    input  logic [RADDR-1:0] i_writereg_e,
    input  logic             i_regwrite_m,
    input  logic             i_memtoreg_m,
    input  logic [RADDR-1:0] i_writereg_m,
    input  logic [WIDTH-1:0] i_aluout_m,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_flush_e,
    output logic             o_pcsrc_d,
    output logic             o_flush_d,
    output logic [WIDTH-1:0] o_pc_branch_d,
    output logic [CNTW-1:0]  o_branch_cnt,
    output logic [CNTW-1:0]  o_taken_cnt
);
    typedef enum logic {IDLE, HOLD} state_t;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    state_t           r_state, w_state_next;
    logic [1:0]       r_cnt, w_cnt_next, w_need;
    logic [CNTW-1:0]  r_branch_cnt, r_taken_cnt;
    logic [WIDTH-1:0] w_a, w_b;
    logic             w_fwd_m, w_hz_e, w_hz_m, w_stall, w_taken, w_resolve;
    assign w_fwd_m = i_regwrite_m & ~i_memtoreg_m & (i_writereg_m != '0);
    assign w_a = (w_fwd_m & (i_writereg_m == i_rs_d)) ? i_aluout_m : i_rd1_d;
    assign w_b = (w_fwd_m & (i_writereg_m == i_rt_d)) ? i_aluout_m : i_rd2_d;
    assign w_hz_e = i_branch_d & i_regwrite_e & (i_writereg_e != '0) &
                    ((i_writereg_e == i_rs_d) | (i_writereg_e == i_rt_d));
    assign w_hz_m = i_branch_d & i_regwrite_m & i_memtoreg_m & (i_writereg_m != '0) &
                    ((i_writereg_m == i_rs_d) | (i_writereg_m == i_rt_d));
    assign w_need = (w_hz_e & i_memtoreg_e) ? 2'd2 : (w_hz_e | w_hz_m) ? 2'd1 : 2'd0;
    assign o_pc_branch_d = i_pc_plus4_d + {i_imm_d[WIDTH-3:0], 2'b00};
    assign o_stall_f = w_stall;
    assign o_stall_d = w_stall;
    assign o_flush_e = w_stall;
    assign o_pcsrc_d = w_taken;
    assign o_flush_d = w_taken;
    assign o_branch_cnt = r_branch_cnt;
    assign o_taken_cnt = r_taken_cnt;
    // stall/resolve decision and next state; a branch resolves only in a hazard-free IDLE cycle
    always_comb begin
        w_state_next = r_state;
        w_cnt_next = r_cnt;
        w_stall = 1'b0;
        w_taken = 1'b0;
        w_resolve = 1'b0;
        if (r_state == HOLD) begin
            w_stall = 1'b1;
            w_cnt_next = r_cnt - 2'd1;
            w_state_next = (r_cnt == 2'd1) ? IDLE : HOLD;
        end else if (w_need != 2'd0) begin
            w_stall = 1'b1;
            w_state_next = (w_need == 2'd2) ? HOLD : IDLE;
            w_cnt_next = (w_need == 2'd2) ? 2'd1 : r_cnt;
        end else begin
            w_resolve = i_branch_d;
            w_taken = i_branch_d & ((w_a == w_b) ^ i_bne_d);
        end
    end
    // state, hold counter and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt <= 2'd0;
            r_branch_cnt <= '0;
            r_taken_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt <= w_cnt_next;
            if (w_resolve && r_branch_cnt != CNT_MAX) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_taken && r_taken_cnt != CNT_MAX) r_taken_cnt <= r_taken_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table-driven and sequence checks of branch_resolve_unit
module tb_branch_resolve_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        branch_d, bne_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m;
    logic [4:0]  rs_d, rt_d, writereg_e, writereg_m;
    logic [31:0] rd1_d, rd2_d, imm_d, pc_plus4_d, aluout_m, pc_branch_d;
    logic        stall_f, stall_d, flush_e, pcsrc_d, flush_d;
    logic [15:0] branch_cnt, taken_cnt;
    int          n_chk = 0, n_fail = 0;
    int          exp_bc = 0, exp_tc = 0;

    typedef struct {
        logic        br, bne;
        logic [4:0]  rs, rt;
        logic [31:0] rd1, rd2, imm, pc4;
        logic        rwe, mre;
        logic [4:0]  wre;
        logic        rwm, mrm;
        logic [4:0]  wrm;
        logic [31:0] alum;
        logic        x_stall, x_pcsrc;
        logic [31:0] x_pcb;
    } vec_t;
    vec_t tv[12];

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .i_branch_d(branch_d), .i_bne_d(bne_d),
        .i_rs_d(rs_d), .i_rt_d(rt_d), .i_rd1_d(rd1_d), .i_rd2_d(rd2_d),
        .i_imm_d(imm_d), .i_pc_plus4_d(pc_plus4_d),
        .i_regwrite_e(regwrite_e), .i_memtoreg_e(memtoreg_e), .i_writereg_e(writereg_e),
        .i_regwrite_m(regwrite_m), .i_memtoreg_m(memtoreg_m), .i_writereg_m(writereg_m),
        .i_aluout_m(aluout_m), .o_stall_f(stall_f), .o_stall_d(stall_d), .o_flush_e(flush_e),
        .o_pcsrc_d(pcsrc_d), .o_flush_d(flush_d), .o_pc_branch_d(pc_branch_d),
        .o_branch_cnt(branch_cnt), .o_taken_cnt(taken_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        branch_d = 0; bne_d = 0; rs_d = 0; rt_d = 0; rd1_d = 0; rd2_d = 0;
        imm_d = 0; pc_plus4_d = 0; regwrite_e = 0; memtoreg_e = 0; writereg_e = 0;
        regwrite_m = 0; memtoreg_m = 0; writereg_m = 0; aluout_m = 0;
    endtask

    task automatic drive(input vec_t v);
        branch_d = v.br; bne_d = v.bne; rs_d = v.rs; rt_d = v.rt; rd1_d = v.rd1; rd2_d = v.rd2;
        imm_d = v.imm; pc_plus4_d = v.pc4; regwrite_e = v.rwe; memtoreg_e = v.mre;
        writereg_e = v.wre; regwrite_m = v.rwm; memtoreg_m = v.mrm; writereg_m = v.wrm;
        aluout_m = v.alum;
    endtask

    task automatic chk_outs(input string nm, input logic s, input logic t);
        chk({nm, ".stall_f"}, {31'd0, stall_f}, {31'd0, s});
        chk({nm, ".stall_d"}, {31'd0, stall_d}, {31'd0, s});
        chk({nm, ".flush_e"}, {31'd0, flush_e}, {31'd0, s});
        chk({nm, ".pcsrc"}, {31'd0, pcsrc_d}, {31'd0, t});
        chk({nm, ".flush_d"}, {31'd0, flush_d}, {31'd0, t});
    endtask

    task automatic chk_cnts(input string nm);
        chk({nm, ".branch_cnt"}, {16'd0, branch_cnt}, exp_bc);
        chk({nm, ".taken_cnt"}, {16'd0, taken_cnt}, exp_tc);
    endtask

    initial begin
        //         br    bne   rs    rt    rd1           rd2           imm           pc4           rwe   mre   wre   rwm   mrm   wrm   alum         stall pcsrc pcb
        tv[0]  = '{1'b1, 1'b0, 5'd1, 5'd2, 32'h5,        32'h5,        32'h4,        32'h0040_0010, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 32'h0040_0020};
        tv[1]  = '{1'b1, 1'b1, 5'd1, 5'd2, 32'h1234,     32'h1234,     32'hFFFF_FFFE, 32'h4,        1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 32'hFFFF_FFFC};
        tv[2]  = '{1'b1, 1'b0, 5'd1, 5'd2, 32'h1,        32'h2,        32'h1,        32'h100,       1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 32'h104};
        tv[3]  = '{1'b1, 1'b1, 5'd1, 5'd2, 32'h1,        32'h2,        32'h0,        32'h200,       1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 32'h200};
        tv[4]  = '{1'b1, 1'b0, 5'd1, 5'd2, 32'h0,        32'h7,        32'h0,        32'h0,         1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd1, 32'h7,       1'b0, 1'b1, 32'h0};
        tv[5]  = '{1'b1, 1'b0, 5'd0, 5'd2, 32'h0,        32'h7,        32'h0,        32'h0,         1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h7,       1'b0, 1'b0, 32'h0};
        tv[6]  = '{1'b1, 1'b0, 5'd1, 5'd2, 32'h3,        32'h9,        32'h0,        32'h0,         1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd2, 32'h3,       1'b0, 1'b1, 32'h0};
        tv[7]  = '{1'b1, 1'b0, 5'd0, 5'd2, 32'h0,        32'h0,        32'h0,        32'h0,         1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 32'h0};
        tv[8]  = '{1'b1, 1'b0, 5'd3, 5'd2, 32'h8,        32'h8,        32'h0,        32'h0,         1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 32'h0};
        tv[9]  = '{1'b1, 1'b0, 5'd1, 5'd5, 32'h8,        32'h8,        32'h0,        32'h0,         1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 32'h0,       1'b1, 1'b0, 32'h0};
        tv[10] = '{1'b0, 1'b0, 5'd3, 5'd2, 32'h8,        32'h8,        32'h10,       32'h100,       1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 32'h140};
        tv[11] = '{1'b1, 1'b0, 5'd3, 5'd2, 32'h8,        32'h8,        32'h0,        32'h0,         1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 32'h0};
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
        #1 chk_outs("reset", 1'b0, 1'b0);
        chk_cnts("reset");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); drive(tv[i]);
            #1 chk_outs($sformatf("v%0d", i), tv[i].x_stall, tv[i].x_pcsrc);
            chk($sformatf("v%0d.pcb", i), pc_branch_d, tv[i].x_pcb);
            if (tv[i].br && !tv[i].x_stall) exp_bc++;
            if (tv[i].x_pcsrc) exp_tc++;
            @(posedge clk); #1 chk_cnts($sformatf("v%0d", i));
        end
        // ALU producer in EX: one stall, then forwarded from MEM
        @(negedge clk); clr(); branch_d = 1; rs_d = 3; rd1_d = 32'h99;
        regwrite_e = 1; writereg_e = 3;
        #1 chk_outs("alu.c1", 1'b1, 1'b0);
        @(negedge clk); clr(); branch_d = 1; rs_d = 3; rd1_d = 32'h99;
        regwrite_m = 1; writereg_m = 3; aluout_m = 0;
        #1 chk_outs("alu.c2", 1'b0, 1'b1);
        exp_bc++; exp_tc++;
        @(posedge clk); #1 chk_cnts("alu");
        // load producer in EX: IDLE stall, HOLD stall, then resolve once
        @(negedge clk); clr(); branch_d = 1; bne_d = 1; rs_d = 4; rt_d = 5;
        regwrite_e = 1; memtoreg_e = 1; writereg_e = 4;
        #1 chk_outs("lw.c1", 1'b1, 1'b0);
        @(negedge clk); clr(); branch_d = 1; bne_d = 1; rs_d = 4; rt_d = 5; rd1_d = 1; rd2_d = 2;
        regwrite_m = 1; memtoreg_m = 1; writereg_m = 4;
        #1 chk_outs("lw.c2", 1'b1, 1'b0);
        @(posedge clk); #1 chk_cnts("lw.hold");
        @(negedge clk); clr(); branch_d = 1; bne_d = 1; rs_d = 4; rt_d = 5; rd1_d = 10; rd2_d = 20;
        #1 chk_outs("lw.c3", 1'b0, 1'b1);
        exp_bc++; exp_tc++;
        @(posedge clk); #1 chk_cnts("lw");
        @(negedge clk); clr();
        @(posedge clk); #1 chk_cnts("lw.once");
        // reset while in HOLD
        @(negedge clk); clr(); branch_d = 1; rs_d = 4; rt_d = 5;
        regwrite_e = 1; memtoreg_e = 1; writereg_e = 4;
        #1 chk_outs("rst.c1", 1'b1, 1'b0);
        @(negedge clk); clr(); rst = 1;
        #1 chk_outs("rst.hold", 1'b1, 1'b0);
        exp_bc = 0; exp_tc = 0;
        @(negedge clk); rst = 0;
        #1 chk_outs("rst.idle", 1'b0, 1'b0);
        chk_cnts("rst");
        @(negedge clk); branch_d = 1; rd1_d = 6; rd2_d = 6;
        #1 chk_outs("rst.resolve", 1'b0, 1'b1);
        @(negedge clk); clr(); rst = 1;
        @(negedge clk); rst = 0;
        // saturation of the branch counter
        branch_d = 1; bne_d = 1; rd1_d = 1; rd2_d = 1;
        repeat (65535) @(posedge clk);
        #1 chk("sat.branch_cnt", {16'd0, branch_cnt}, 32'hFFFF);
        chk("sat.taken_cnt", {16'd0, taken_cnt}, 32'h0);
        @(posedge clk); #1 chk("sat.hold", {16'd0, branch_cnt}, 32'hFFFF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
